// File: rtl/br_flow_serializer_arb_if.sv
// Interface bundle for br_flow_serializer_arb: the wide per-flow push side and the
// single pop side toward the serializer. The slave modport is the arbiter's view.
interface br_flow_serializer_arb_if #(
    parameter int NumFlows      = 2,
    parameter int Width         = 2,
    parameter int DontCareWidth = 1,
    parameter int MetadataWidth = 1
);
    localparam int FlowIdWidth = $clog2(NumFlows);

    logic [NumFlows-1:0]                    push_ready;
    logic [NumFlows-1:0]                    push_valid;
    logic [NumFlows-1:0][Width-1:0]         push_data;
    logic [NumFlows-1:0]                    push_last;
    logic [NumFlows-1:0][DontCareWidth-1:0] push_last_dont_care_count;
    logic [NumFlows-1:0][MetadataWidth-1:0] push_metadata;

    logic                     pop_ready;
    logic                     pop_valid;
    logic [Width-1:0]         pop_data;
    logic                     pop_last;
    logic [DontCareWidth-1:0] pop_last_dont_care_count;
    logic [MetadataWidth-1:0] pop_metadata;
    logic [FlowIdWidth-1:0]   pop_flow_id;

    modport master (
        input  push_ready,
        output push_valid,
        output push_data,
        output push_last,
        output push_last_dont_care_count,
        output push_metadata,
        output pop_ready,
        input  pop_valid,
        input  pop_data,
        input  pop_last,
        input  pop_last_dont_care_count,
        input  pop_metadata,
        input  pop_flow_id
    );

    modport slave (
        output push_ready,
        input  push_valid,
        input  push_data,
        input  push_last,
        input  push_last_dont_care_count,
        input  push_metadata,
        input  pop_ready,
        output pop_valid,
        output pop_data,
        output pop_last,
        output pop_last_dont_care_count,
        output pop_metadata,
        output pop_flow_id
    );
endinterface

// File: rtl/br_flow_serializer_arb.sv
// Packet-atomic round-robin arbiter in front of a wide-to-narrow serializer.
// Combinational datapath; only lock state, locked flow and rr pointer are registered.
module br_flow_serializer_arb #(
    parameter int NumFlows      = 2,
    parameter int Width         = 2,
    parameter int DontCareWidth = 1,
    parameter int MetadataWidth = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    br_flow_serializer_arb_if.slave   bus
);
    localparam int FlowIdWidth = $clog2(NumFlows);
    localparam logic [FlowIdWidth-1:0] LastId = FlowIdWidth'(NumFlows - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [FlowIdWidth-1:0] r_locked_id;
    logic [FlowIdWidth-1:0] w_locked_id_nxt;
    logic [FlowIdWidth-1:0] r_rr_ptr;
    logic [FlowIdWidth-1:0] w_rr_ptr_nxt;

    logic [FlowIdWidth-1:0] w_rr_grant;
    logic                   w_rr_found;
    logic [FlowIdWidth-1:0] w_grant;
    logic                   w_pop_valid;
    logic                   w_accept;
    logic [NumFlows-1:0]    w_push_ready;

    // Round-robin scan starting at rr_ptr; falls back to flow 0 when nobody is valid
    always_comb begin
        w_rr_grant = '0;
        w_rr_found = 1'b0;
        for (int k = 0; k < NumFlows; k++) begin
            logic [FlowIdWidth-1:0] idx;
            idx = FlowIdWidth'((int'(r_rr_ptr) + k) % NumFlows);
            if (!w_rr_found && bus.push_valid[idx]) begin
                w_rr_found = 1'b1;
                w_rr_grant = idx;
            end
        end
    end

    assign w_grant     = (r_state == LOCKED) ? r_locked_id : w_rr_grant;
    assign w_pop_valid = rst_n && bus.push_valid[w_grant];
    assign w_accept    = w_pop_valid && bus.pop_ready;

    // Only the granted flow sees ready, and only when its flit is taken
    always_comb begin
        w_push_ready = '0;
        if (w_accept) begin
            w_push_ready[w_grant] = 1'b1;
        end
    end

    assign bus.push_ready               = w_push_ready;
    assign bus.pop_valid                = w_pop_valid;
    assign bus.pop_data                 = bus.push_data[w_grant];
    assign bus.pop_last                 = bus.push_last[w_grant];
    assign bus.pop_last_dont_care_count = bus.push_last_dont_care_count[w_grant];
    assign bus.pop_metadata             = bus.push_metadata[w_grant];
    assign bus.pop_flow_id              = w_grant;

    // Next-state: lock on any presented flit unless it is an accepted last flit
    always_comb begin
        w_state_nxt     = r_state;
        w_locked_id_nxt = r_locked_id;
        w_rr_ptr_nxt    = r_rr_ptr;
        if (w_pop_valid) begin
            if (w_accept && bus.pop_last) begin
                w_state_nxt  = IDLE;
                w_rr_ptr_nxt = (w_grant == LastId) ? '0 : w_grant + 1'b1;
            end else begin
                w_state_nxt     = LOCKED;
                w_locked_id_nxt = w_grant;
            end
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_locked_id <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_locked_id <= w_locked_id_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    a_pop_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (w_pop_valid && !bus.pop_ready) |=> (w_pop_valid && $stable(w_grant)));
    a_ready_onehot0: assert property (@(posedge clk) $onehot0(w_push_ready));
    a_valid_src: assert property (@(posedge clk)
        w_pop_valid |-> bus.push_valid[w_grant]);
    a_no_valid_rst: assert property (@(posedge clk) !rst_n |-> !w_pop_valid);
    a_lock_grant: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == LOCKED) |-> (w_grant == r_locked_id));

    c_all_contend: cover property (@(posedge clk) disable iff (!rst_n)
        &bus.push_valid);
    c_lock_bp: cover property (@(posedge clk) disable iff (!rst_n)
        (r_state == LOCKED) && w_pop_valid && !bus.pop_ready);
    c_rr_wrap: cover property (@(posedge clk) disable iff (!rst_n)
        w_accept && bus.pop_last && (w_grant == LastId));
    c_single_flit: cover property (@(posedge clk) disable iff (!rst_n)
        (r_state == IDLE) && w_accept && bus.pop_last);
endmodule
